// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer with redirect and drain handling.
module fetch_ctrl #(
    parameter logic [63:0] PC_INIT = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic [31:0] fetch_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, OUT} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d, pend_pc_q, pend_pc_d, inst_pc_q, inst_pc_d;
    logic [31:0] inst_q, inst_d, fetch_cnt_q, fetch_cnt_d;
    logic        inst_valid_q, inst_valid_d;
    logic [63:0] rd_pc;
    logic        unused_addr_ok;

    assign unused_addr_ok = iresp_addr_ok;
    assign rd_pc = {redirect_pc[63:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        case (state_q)
            IDLE: begin
                pc_d    = redirect_valid ? rd_pc : pc_q;
                state_d = REQ;
            end
            REQ: begin
                if (iresp_data_ok && redirect_valid) begin
                    pc_d = rd_pc;
                end else if (redirect_valid) begin
                    pend_pc_d = rd_pc;
                    state_d   = DRAIN;
                end else if (iresp_data_ok) begin
                    inst_d       = iresp_data;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + 64'd4;
                    state_d      = OUT;
                end
            end
            DRAIN: begin
                // pc still holds the in-flight address, so the bus stays stable until data_ok
                if (iresp_data_ok) begin
                    pc_d    = redirect_valid ? rd_pc : pend_pc_q;
                    state_d = REQ;
                end else if (redirect_valid) begin
                    pend_pc_d = rd_pc;
                end
            end
            OUT: begin
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    pc_d         = rd_pc;
                    state_d      = REQ;
                end else if (!stall) begin
                    inst_valid_d = 1'b0;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= PC_INIT;
            pend_pc_q    <= 64'd0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 64'd0;
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign ireq_valid = (state_q == REQ) || (state_q == DRAIN);
    assign ireq_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_cnt  = fetch_cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed test-plan scenarios plus random traffic against a transaction-level fetch model.
module tb_fetch_ctrl;
    localparam logic [63:0] PC_INIT = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok = 1'b0;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [31:0] fetch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl #(.PC_INIT(PC_INIT)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // reference: a fetch is either waiting to start, outstanding (possibly doomed), or delivered and held
    logic        m_start, m_busy, m_drop, m_hold;
    logic [63:0] m_pc, m_pend, m_inst_pc;
    logic [31:0] m_inst, m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_start = 1'b1; m_busy = 1'b0; m_drop = 1'b0; m_hold = 1'b0;
        m_pc = PC_INIT; m_pend = 64'd0; m_inst_pc = 64'd0; m_inst = 32'd0; m_cnt = 32'd0;
    endtask

    task automatic m_check();
        check("ireq_valid", 64'(ireq_valid), 64'(m_busy));
        check("ireq_addr", ireq_addr, m_pc);
        check("inst_valid", 64'(inst_valid), 64'(m_hold));
        check("inst", 64'(inst), 64'(m_inst));
        check("inst_pc", inst_pc, m_inst_pc);
        check("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
    endtask

    task automatic m_step();
        logic [63:0] tgt;
        tgt = redirect_pc & ~64'd3;
        if (m_start) begin
            if (redirect_valid) m_pc = tgt;
            m_start = 1'b0;
            m_busy = 1'b1;
        end else if (m_busy) begin
            if (iresp_data_ok && m_drop) begin
                m_pc = redirect_valid ? tgt : m_pend;
                m_drop = 1'b0;
            end else if (iresp_data_ok && redirect_valid) begin
                m_pc = tgt;
            end else if (iresp_data_ok) begin
                m_inst = iresp_data;
                m_inst_pc = m_pc;
                m_pc = m_pc + 64'd4;
                m_busy = 1'b0;
                m_hold = 1'b1;
            end else if (redirect_valid) begin
                m_pend = tgt;
                m_drop = 1'b1;
            end
        end else if (m_hold) begin
            if (redirect_valid) begin
                m_hold = 1'b0;
                m_pc = tgt;
                m_busy = 1'b1;
            end else if (!stall) begin
                m_hold = 1'b0;
                m_cnt = m_cnt + 32'd1;
                m_busy = 1'b1;
            end
        end
    endtask

    // one clock: apply inputs, compare at negedge, advance model, return at posedge+1
    task automatic drive(input logic dok, input logic rv, input logic [63:0] rpc, input logic st);
        iresp_data_ok = dok;
        iresp_addr_ok = dok;
        redirect_valid = rv;
        redirect_pc = rpc;
        stall = st;
        @(negedge clk);
        m_check();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        m_reset();
        @(posedge clk);
        #1;
        do_reset();
        check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        check("rst_ireq_addr", ireq_addr, PC_INIT);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        iresp_data = 32'h0000_0013;
        drive(0, 0, 0, 0);
        // three back-to-back fetches with 2-cycle cache latency
        for (int k = 0; k < 3; k++) begin
            check("seq_addr", ireq_addr, PC_INIT + 64'(4 * k));
            check("seq_valid", 64'(ireq_valid), 64'd1);
            drive(0, 0, 0, 0);
            drive(0, 0, 0, 0);
            drive(1, 0, 0, 0);
            check("seq_inst", 64'(inst), 64'h13);
            check("seq_inst_pc", inst_pc, PC_INIT + 64'(4 * k));
            drive(0, 0, 0, 0);
            check("seq_cnt", 64'(fetch_cnt), 64'(k + 1));
        end
        // decode stall holds the instruction
        iresp_data = 32'hCAFE_0001;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 64'(inst_valid), 64'd1);
            check("stall_ireq", 64'(ireq_valid), 64'd0);
            check("stall_inst", 64'(inst), 64'hCAFE_0001);
            check("stall_pc", inst_pc, 64'h8000_000C);
            drive(0, 0, 0, 1);
        end
        drive(0, 0, 0, 0);
        check("post_stall_addr", ireq_addr, 64'h8000_0010);
        check("post_stall_req", 64'(ireq_valid), 64'd1);
        // redirect while the request is outstanding: address holds, result dropped
        drive(0, 1, 64'h8000_0100, 0);
        for (int k = 0; k < 3; k++) begin
            check("drain_addr", ireq_addr, 64'h8000_0010);
            check("drain_req", 64'(ireq_valid), 64'd1);
            drive(0, 0, 0, 0);
        end
        drive(1, 0, 0, 0);
        check("drain_next", ireq_addr, 64'h8000_0100);
        check("drain_no_inst", 64'(inst_valid), 64'd0);
        // redirect coincident with data_ok
        drive(0, 0, 0, 0);
        drive(1, 1, 64'h8000_0203, 0);
        check("same_addr", ireq_addr, 64'h8000_0200);
        check("same_req", 64'(ireq_valid), 64'd1);
        check("same_no_inst", 64'(inst_valid), 64'd0);
        check("same_cnt", 64'(fetch_cnt), 64'd4);
        // redirect beats a stalled instruction
        drive(1, 0, 0, 1);
        check("out_valid", 64'(inst_valid), 64'd1);
        drive(0, 1, 64'h8000_0400, 1);
        check("out_redir_valid", 64'(inst_valid), 64'd0);
        check("out_redir_cnt", 64'(fetch_cnt), 64'd4);
        check("out_redir_addr", ireq_addr, 64'h8000_0400);
        // async reset during DRAIN, then a stale data_ok
        drive(0, 1, 64'h8000_0800, 0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_req", 64'(ireq_valid), 64'd0);
        check("arst_addr", ireq_addr, PC_INIT);
        check("arst_cnt", 64'(fetch_cnt), 64'd0);
        check("arst_inst", 64'(inst), 64'd0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1, 0, 0, 0);
        check("restart_addr", ireq_addr, PC_INIT);
        drive(0, 0, 0, 0);
        check("restart_no_inst", 64'(inst_valid), 64'd0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            iresp_data = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                      {$urandom, $urandom}, $urandom_range(0, 1) == 1);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer sitting between the PC/redirect logic and the instruction-bus port (ibus request/response to the I-cache).
- Issues one fetch at a time and holds the request stable until the cache completes it.
- Buffers the returned instruction until the decode stage accepts it.
- Handles branch redirects at any point, including discarding a fetch already in flight.

Parameters:
PC_INIT, 64'h8000_0000, PC value loaded at reset.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ireq_valid  out  1  fetch request valid (ibus valid)
ireq_addr  out  64  fetch address (ibus addr)
iresp_addr_ok  in  1  cache accepted address
iresp_data_ok  in  1  cache returns data; completes the request
iresp_data  in  32  fetched instruction word
redirect_valid  in  1  branch/jump redirect, single-cycle pulse
redirect_pc  in  64  redirect target
stall  in  1  decode not ready
inst_valid  out  1  instruction available to decode
inst  out  32  instruction word
inst_pc  out  64  PC of inst
fetch_cnt  out  32  completed, delivered fetches (wraps)

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, pc=PC_INIT, ireq_valid=0, ireq_addr=PC_INIT.
  - inst_valid=0, inst=0, inst_pc=0, fetch_cnt=0, pend_pc=0.
  - Reset asserted mid-request abandons it; no data is captured afterwards.
- All outputs are registered or decoded from state. ireq_addr always equals pc, or the in-flight address in DRAIN.
- At most one outstanding request.
- A request completes on iresp_data_ok=1. iresp_addr_ok is informational and may arrive in the same cycle as data_ok or earlier.
- Address handling:
  - pc advances by +4 with 64-bit wrap-around.
  - redirect_pc[1:0] is forced to 0 when loaded.

States and transitions:
- IDLE: ireq_valid=0.
  - Goes to REQ on the next cycle.
  - redirect_valid in IDLE loads pc.
- REQ: ireq_valid=1, ireq_addr=pc; address held stable until data_ok. Priority within REQ:
  - data_ok and redirect_valid in the same cycle: data discarded, pc<=redirect_pc, stay REQ. New address appears next cycle; ireq_valid stays 1.
  - redirect_valid without data_ok: pend_pc<=redirect_pc, go to DRAIN.
  - data_ok alone: inst<=iresp_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4, go to OUT.
- DRAIN: ireq_valid=1, ireq_addr = the old in-flight address.
  - A further redirect overwrites pend_pc (latest wins).
  - On data_ok: data discarded, pc<=pend_pc (or the same-cycle redirect_pc if redirect_valid), go to REQ.
- OUT: ireq_valid=0, inst_valid=1.
  - redirect_valid: inst_valid<=0, pc<=redirect_pc, go to REQ. Redirect wins over acceptance; fetch_cnt is not incremented.
  - stall=0 (instruction accepted): inst_valid<=0, fetch_cnt+=1, go to REQ.
  - stall=1: hold inst, inst_pc and inst_valid unchanged.
- Latency and throughput:
  - First request appears 1 cycle after reset release.
  - inst_valid rises the cycle after data_ok.
  - The next request is issued the cycle after acceptance.
  - Best-case throughput: 1 instruction per 2 cycles plus cache latency.
- iresp_data_ok outside REQ/DRAIN is ignored.

Test Plan:
- Reset release, cache answers data_ok+addr_ok 2 cycles after each request with data 32'h00000013, stall=0.
  -> ireq_addr = 8000_0000, 8000_0004, 8000_0008 in turn.
  -> inst_pc matches each address, inst=32'h13, fetch_cnt counts 1,2,3.
- Data arrives with stall=1 held for 3 cycles.
  -> inst_valid=1 and inst/inst_pc constant for 3 cycles.
  -> ireq_valid=0 throughout; next request 8000_0004 issued the cycle after stall drops.
- redirect_pc=64'h8000_0100 pulsed while a request to 8000_0004 waits 4 cycles.
  -> ireq_addr stays 8000_0004 until data_ok.
  -> no inst_valid; next request 8000_0100.
- Redirect to 8000_0203 in the same cycle as data_ok.
  -> data dropped, next ireq_addr = 8000_0200, fetch_cnt unchanged.
- Redirect while in OUT with stall=1.
  -> inst_valid falls next cycle, fetch_cnt unchanged, request to redirect target follows.
- Assert reset during DRAIN, then pulse data_ok after reset falls.
  -> outputs return to reset values immediately; stale data_ok ignored; fetch restarts at PC_INIT.
